reg_8_16b_reader: RTL and testbench

Read-side companion to the 8x16 register bank. Takes the bank's eight parallel register outputs and serves them through one registered valid/ready read port. Supports two kinds of access:
- single random reads, with write-to-read bypass;
- a "dump" mode that streams r0..r7 in order, used by the debug/trace path.

Sits between the register bank and its consumers (debug unit, test harness).

---
 rtl/reg_8_16b_reader.sv | 170 +++++++++++++++++
 tb/tb_reg_8_16b_reader.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_8_16b_reader.sv
// reg_8_16b_reader
//
// Read-side companion to the 8x16 register bank. Serves the bank's eight
// parallel register outputs through a single registered valid/ready beat
// slot. Two access kinds:
//   - single random reads (rd_req/rd_sel), acknowledged combinationally;
//   - a dump that streams r0..r7 in order, ending with rd_last on idx 7.
// A write snooped in the same cycle a beat loads replaces the register
// value, so the consumer always sees the post-edge contents.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active-low
//   r0_in..r7_in in   current contents of bank registers 0..7
//   wr_en        in   bank write enable (snooped)
//   wr_sel       in   bank write select (snooped)
//   wr_data      in   bank write data (snooped)
//   rd_req       in   single-read request
//   rd_sel       in   register index for single read
//   dump_start   in   start sequential dump of r0..r7
//   rd_ready     in   consumer accepts current beat
//   req_ack      out  rd_req accepted this cycle (combinational)
//   rd_valid     out  rd_data/rd_idx/rd_last valid
//   rd_data      out  read data (registered)
//   rd_idx       out  index of register in rd_data
//   rd_last      out  final beat of a dump
//   busy         out  high while dumping
module reg_8_16b_reader #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] r0_in,
    input  logic [WIDTH-1:0] r1_in,
    input  logic [WIDTH-1:0] r2_in,
    input  logic [WIDTH-1:0] r3_in,
    input  logic [WIDTH-1:0] r4_in,
    input  logic [WIDTH-1:0] r5_in,
    input  logic [WIDTH-1:0] r6_in,
    input  logic [WIDTH-1:0] r7_in,
    input  logic             wr_en,
    input  logic [2:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    input  logic [2:0]       rd_sel,
    input  logic             dump_start,
    input  logic             rd_ready,
    output logic             req_ack,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [2:0]       rd_idx,
    output logic             rd_last,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        DUMP = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_cnt;
    logic [2:0]       w_cnt_nxt;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [2:0]       r_idx;
    logic             r_last;

    logic             w_slot_free;
    logic             w_load;
    logic [2:0]       w_load_idx;
    logic             w_load_last;
    logic [WIDTH-1:0] w_reg_val;
    logic [WIDTH-1:0] w_load_data;

    // The slot can take a new beat when empty or when its beat leaves now.
    assign w_slot_free = !r_valid || rd_ready;

    always_comb begin
        case (w_load_idx)
            3'd0:    w_reg_val = r0_in;
            3'd1:    w_reg_val = r1_in;
            3'd2:    w_reg_val = r2_in;
            3'd3:    w_reg_val = r3_in;
            3'd4:    w_reg_val = r4_in;
            3'd5:    w_reg_val = r5_in;
            3'd6:    w_reg_val = r6_in;
            default: w_reg_val = r7_in;
        endcase
    end

    // Same-cycle write to the register being loaded wins: the bank will hold
    // wr_data after this edge, and that is what the consumer must see.
    assign w_load_data = (wr_en && (wr_sel == w_load_idx)) ? wr_data : w_reg_val;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_load_idx  = 3'd0;
        w_load_last = 1'b0;
        req_ack     = 1'b0;
        case (r_state)
            IDLE: begin
                // dump_start outranks rd_req; the entry cycle loads nothing.
                if (dump_start && w_slot_free) begin
                    w_state_nxt = DUMP;
                    w_cnt_nxt   = 3'd0;
                end else if (rd_req && w_slot_free) begin
                    req_ack    = 1'b1;
                    w_load     = 1'b1;
                    w_load_idx = rd_sel;
                end
            end
            DUMP: begin
                // Counter only advances on a load, so back-pressure stalls it.
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_load_idx  = r_cnt;
                    w_load_last = (r_cnt == 3'd7);
                    if (r_cnt == 3'd7) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Output slot: payload changes only on a load, so it holds under stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= 3'd0;
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_load_data;
            r_idx   <= w_load_idx;
            r_last  <= w_load_last;
        end else if (rd_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign rd_valid = r_valid;
    assign rd_data  = r_data;
    assign rd_idx   = r_idx;
    assign rd_last  = r_last;
    assign busy     = (r_state == DUMP);

endmodule

// File: tb/tb_reg_8_16b_reader.sv
module tb_reg_8_16b_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] regs [8];
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic        rd_req;
    logic [2:0]  rd_sel;
    logic        dump_start;
    logic        rd_ready;
    logic        req_ack;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [2:0]  rd_idx;
    logic        rd_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_8_16b_reader #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .r0_in      (regs[0]),
        .r1_in      (regs[1]),
        .r2_in      (regs[2]),
        .r3_in      (regs[3]),
        .r4_in      (regs[4]),
        .r5_in      (regs[5]),
        .r6_in      (regs[6]),
        .r7_in      (regs[7]),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_sel     (rd_sel),
        .dump_start (dump_start),
        .rd_ready   (rd_ready),
        .req_ack    (req_ack),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_idx     (rd_idx),
        .rd_last    (rd_last),
        .busy       (busy)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        rd_req = 1'b0; dump_start = 1'b0; wr_en = 1'b0; rd_ready = 1'b1;
        tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({rd_valid, rd_data, rd_idx, rd_last, busy} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b d=%h i=%0d l=%b b=%b exp all zero",
                     rd_valid, rd_data, rd_idx, rd_last, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if ({rd_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release got v=%b b=%b exp 0 0", rd_valid, busy);
        end
    endtask

    task automatic test_single();
        regs[3] = 16'hBEEF; rd_ready = 1'b1; rd_req = 1'b1; rd_sel = 3'd3;
        #1;
        checks++;
        if (req_ack !== 1'b1) begin
            errors++; $display("FAIL single_ack got %b exp 1", req_ack);
        end
        tick();
        rd_req = 1'b0;
        checks++;
        if ({rd_valid, rd_data, rd_idx, rd_last} !== {1'b1, 16'hBEEF, 3'd3, 1'b0}) begin
            errors++;
            $display("FAIL single_beat got v=%b d=%h i=%0d l=%b exp 1 beef 3 0",
                     rd_valid, rd_data, rd_idx, rd_last);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL single_drop got %b exp 0", rd_valid);
        end
    endtask

    task automatic test_bypass();
        regs[5] = 16'h1111; rd_ready = 1'b1;
        rd_req = 1'b1; rd_sel = 3'd5; wr_en = 1'b1; wr_sel = 3'd5; wr_data = 16'h2222;
        tick();
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, 16'h2222}) begin
            errors++; $display("FAIL bypass_hit got v=%b d=%h exp 1 2222", rd_valid, rd_data);
        end
        wr_sel = 3'd4;
        tick();
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, 16'h1111}) begin
            errors++; $display("FAIL bypass_miss got v=%b d=%h exp 1 1111", rd_valid, rd_data);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [15:0] r2v;
        regs[1] = 16'h00A5; rd_ready = 1'b1; rd_req = 1'b1; rd_sel = 3'd1;
        tick();
        rd_req = 1'b0; rd_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({rd_valid, rd_data, rd_idx} !== {1'b1, 16'h00A5, 3'd1}) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got v=%b d=%h i=%0d exp 1 00a5 1",
                         c, rd_valid, rd_data, rd_idx);
            end
            rd_req = 1'b1; rd_sel = 3'd2;
            #1;
            checks++;
            if (req_ack !== 1'b0) begin
                errors++; $display("FAIL bp_req_blocked cyc %0d got %b exp 0", c, req_ack);
            end
            tick();
        end
        r2v = 16'($urandom);
        regs[2] = r2v; rd_ready = 1'b1;
        #1;
        checks++;
        if (req_ack !== 1'b1) begin
            errors++; $display("FAIL bp_handoff_ack got %b exp 1", req_ack);
        end
        tick();
        rd_req = 1'b0;
        checks++;
        if ({rd_valid, rd_data, rd_idx} !== {1'b1, r2v, 3'd2}) begin
            errors++;
            $display("FAIL bp_second_beat got v=%b d=%h i=%0d exp 1 %h 2",
                     rd_valid, rd_data, rd_idx, r2v);
        end
        drain();
    endtask

    task automatic test_dump_full();
        logic [15:0] nv;
        for (int i = 0; i < 8; i++) regs[i] = 16'(16'h0100 + i);
        rd_ready = 1'b1; dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rd_req = 1'b1; rd_sel = 3'($urandom);
            #1;
            checks++;
            if ({busy, req_ack} !== 2'b10) begin
                errors++;
                $display("FAIL dump_busy_ignore k %0d got busy=%b ack=%b exp 1 0", k, busy, req_ack);
            end
            tick();
            rd_req = 1'b0;
            checks++;
            if ({rd_valid, rd_data, rd_idx, rd_last} !== {1'b1, 16'(16'h0100 + k), 3'(k), (k == 7)}) begin
                errors++;
                $display("FAIL dump_beat k %0d got v=%b d=%h i=%0d l=%b", k,
                         rd_valid, rd_data, rd_idx, rd_last);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL dump_busy_end got %b exp 0", busy);
        end
        // First IDLE cycle: idx-7 beat leaves and a read is accepted together.
        nv = 16'($urandom);
        regs[6] = nv; rd_req = 1'b1; rd_sel = 3'd6;
        #1;
        checks++;
        if (req_ack !== 1'b1) begin
            errors++; $display("FAIL dump_after_ack got %b exp 1", req_ack);
        end
        tick();
        rd_req = 1'b0;
        checks++;
        if ({rd_valid, rd_data, rd_idx, rd_last} !== {1'b1, nv, 3'd6, 1'b0}) begin
            errors++;
            $display("FAIL dump_after_beat got v=%b d=%h i=%0d l=%b exp 1 %h 6 0",
                     rd_valid, rd_data, rd_idx, rd_last, nv);
        end
        drain();
    endtask

    task automatic test_dump_random();
        int          got = 0;
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [19:0] held = '0;
        for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
        rd_ready = 1'b1; dump_start = 1'b1; rd_req = 1'b1; rd_sel = 3'd2;
        #1;
        checks++;
        if (req_ack !== 1'b0) begin
            errors++; $display("FAIL dump_prio_ack got %b exp 0", req_ack);
        end
        tick();
        dump_start = 1'b0; rd_req = 1'b0;
        while (got < 8 && cyc < 200) begin
            if (stalled && rd_valid) begin
                checks++;
                if ({rd_data, rd_idx, rd_last} !== held) begin
                    errors++;
                    $display("FAIL dump_stall_hold got %h exp %h", {rd_data, rd_idx, rd_last}, held);
                end
            end
            rd_ready = 1'($urandom);
            rd_req = busy ? 1'($urandom) : 1'b0;
            #1;
            if (rd_req) begin
                checks++;
                if (req_ack !== 1'b0) begin
                    errors++; $display("FAIL dump_rand_req got ack %b exp 0", req_ack);
                end
            end
            if (rd_valid && rd_ready) begin
                checks++;
                if ({rd_data, rd_idx, rd_last} !== {regs[got], 3'(got), (got == 7)}) begin
                    errors++;
                    $display("FAIL dump_rand_beat n %0d got d=%h i=%0d l=%b exp %h %0d %b", got,
                             rd_data, rd_idx, rd_last, regs[got], got, (got == 7));
                end
                got++;
            end
            stalled = rd_valid && !rd_ready;
            held = {rd_data, rd_idx, rd_last};
            tick();
            cyc++;
        end
        checks++;
        if (got != 8) begin
            errors++; $display("FAIL dump_rand_count got %0d exp 8", got);
        end
        rd_req = 1'b0; rd_ready = 1'b1;
        checks++;
        if ({rd_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL dump_rand_extra got v=%b b=%b exp 0 0", rd_valid, busy);
        end
        drain();
    endtask

    task automatic test_random_reads();
        logic        m_has = 1'b0;
        logic [15:0] m_data = '0;
        logic [2:0]  m_idx = '0;
        logic        exp_ack;
        for (int n = 0; n < 40; n++) begin
            rd_req = 1'($urandom); rd_sel = 3'($urandom); rd_ready = 1'($urandom);
            wr_en = 1'($urandom); wr_sel = 3'($urandom); wr_data = 16'($urandom);
            regs[rd_sel] = 16'($urandom);
            #1;
            exp_ack = rd_req && (!m_has || rd_ready);
            checks++;
            if (req_ack !== exp_ack) begin
                errors++; $display("FAIL rand_ack n %0d got %b exp %b", n, req_ack, exp_ack);
            end
            if (exp_ack) begin
                m_has = 1'b1; m_idx = rd_sel;
                m_data = (wr_en && wr_sel == rd_sel) ? wr_data : regs[rd_sel];
            end else if (rd_ready) begin
                m_has = 1'b0;
            end
            tick();
            checks++;
            if (rd_valid !== m_has || (m_has && {rd_data, rd_idx, rd_last} !== {m_data, m_idx, 1'b0})) begin
                errors++;
                $display("FAIL rand_beat n %0d got v=%b d=%h i=%0d l=%b exp %b %h %0d 0", n,
                         rd_valid, rd_data, rd_idx, rd_last, m_has, m_data, m_idx);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_dump();
        int          cyc = 0;
        logic [15:0] v0;
        for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
        rd_ready = 1'b1; dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        while (!(rd_valid && rd_idx == 3'd3) && cyc < 20) begin
            tick(); cyc++;
        end
        checks++;
        if (!(rd_valid && rd_idx == 3'd3)) begin
            errors++; $display("FAIL rstmid_reach got v=%b i=%0d exp 1 3", rd_valid, rd_idx);
        end
        rd_ready = 1'b0;
        #2;
        checks++;
        if ({rd_valid, busy} !== 2'b11) begin
            errors++; $display("FAIL rstmid_pre got v=%b b=%b exp 1 1", rd_valid, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({rd_valid, busy, rd_data, rd_idx, rd_last} !== 22'd0) begin
            errors++;
            $display("FAIL rstmid_async got v=%b b=%b d=%h i=%0d l=%b exp zeros",
                     rd_valid, busy, rd_data, rd_idx, rd_last);
        end
        #1;
        rst = 1'b1;
        tick();
        v0 = 16'($urandom);
        regs[0] = v0; rd_ready = 1'b1; rd_req = 1'b1; rd_sel = 3'd0;
        #1;
        checks++;
        if (req_ack !== 1'b1) begin
            errors++; $display("FAIL rstmid_ack got %b exp 1", req_ack);
        end
        tick();
        rd_req = 1'b0;
        checks++;
        if ({rd_valid, rd_data, rd_idx, rd_last, busy} !== {1'b1, v0, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_read got v=%b d=%h i=%0d l=%b b=%b exp 1 %h 0 0 0",
                     rd_valid, rd_data, rd_idx, rd_last, busy, v0);
        end
        drain();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = '0;
        wr_en = 1'b0; wr_sel = '0; wr_data = '0;
        rd_req = 1'b0; rd_sel = '0; dump_start = 1'b0; rd_ready = 1'b0;
        test_reset();
        test_single();
        test_bypass();
        test_backpressure();
        test_dump_full();
        test_dump_random();
        test_random_reads();
        test_reset_mid_dump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
